// File: rtl/seq_multiply_add.sv
// Sequential shift-add unit: d = q*m + r, one multiplier bit per clock, start/busy/done handshake.
// Optional `REM_CHECK_EN adds rem_err, flagging an invalid remainder (m == 0 or r >= m).
module seq_multiply_add #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   q,
    input  logic [WIDTH-1:0]   m,
    input  logic [WIDTH-1:0]   r,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] d
`ifdef REM_CHECK_EN
    ,
    output logic               rem_err
`endif
);

    // Handshake: start is sampled only in IDLE together with q/m/r; busy is high
    // from the cycle after the start edge until done; done pulses for one cycle
    // with d (and rem_err) valid, and both hold until the next result.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               last_step;

`ifdef REM_CHECK_EN
    logic [WIDTH-1:0]   m_lat;
    logic [WIDTH-1:0]   r_lat;
`endif

    // Partial product is added before the shift so the final step's sum goes straight to d.
    assign acc_nxt   = acc + (mplier[0] ? mcand : '0);
    assign last_step = (state == RUN) && (cnt == LAST_CNT);

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST_CNT) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            d      <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                acc    <= {{WIDTH{1'b0}}, r};
                mcand  <= {{WIDTH{1'b0}}, m};
                mplier <= q;
                cnt    <= '0;
            end else if (state == RUN) begin
                acc    <= acc_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end
            if (last_step) d <= acc_nxt;
        end
    end

`ifdef REM_CHECK_EN
    // The check uses the operands captured at start, not the live inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_lat   <= '0;
            r_lat   <= '0;
            rem_err <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                m_lat <= m;
                r_lat <= r;
            end
            if (last_step) rem_err <= (m_lat == '0) || (r_lat >= m_lat);
        end
    end
`endif

endmodule
